// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle between the two masters and the arbiter, including the muxed slave-side signals.
// slave: arbiter view. master: view of the requesters and the slave read-data source.
interface ahb_master_arbiter_if;
  logic        m0_req,    m1_req;
  logic        m0_lock,   m1_lock;
  logic [31:0] m0_haddr,  m1_haddr;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_gnt,    m1_gnt;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [31:0] m_hrdata;
  logic [1:0]  bus_owner;

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock,
    input  m0_haddr, m1_haddr, m0_hwrite, m1_hwrite, m0_hwdata, m1_hwdata,
    input  HRDATA,
    output m0_gnt, m1_gnt, HADDR, HWRITE, HWDATA, m_hrdata, bus_owner
  );

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock,
    output m0_haddr, m1_haddr, m0_hwrite, m1_hwrite, m0_hwdata, m1_hwdata,
    output HRDATA,
    input  m0_gnt, m1_gnt, HADDR, HWRITE, HWDATA, m_hrdata, bus_owner
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-lite arbiter: round-robin with bounded tenure, lock override,
// and a combinational address/write/data mux onto the shared slave bus.
module ahb_master_arbiter #(
  parameter int unsigned MAX_TENURE = 8
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_master_arbiter_if.slave  bus
);

  localparam int unsigned     CW      = $clog2(MAX_TENURE + 1);
  localparam logic [CW-1:0]   TEN_MAX = CW'(MAX_TENURE - 1);

  // Encodings equal the bus_owner values so the output is the state itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tenure_q, tenure_d;
  logic          last_owner_q, last_owner_d;   // 1 = M1
  logic          contested;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      tenure_q     <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tenure_q     <= tenure_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tenure_d     = tenure_q;
    last_owner_d = last_owner_q;
    contested    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = last_owner_q ? GNT0 : GNT1;
        else if (bus.m0_req)          state_d = GNT0;
        else if (bus.m1_req)          state_d = GNT1;
      end
      GNT0: begin
        contested = bus.m1_req;
        if (!bus.m0_req)
          state_d = bus.m1_req ? GNT1 : IDLE;
        else if (bus.m1_req && !bus.m0_lock && (tenure_q == TEN_MAX))
          state_d = GNT1;
      end
      GNT1: begin
        contested = bus.m0_req;
        if (!bus.m1_req)
          state_d = bus.m0_req ? GNT0 : IDLE;
        else if (bus.m0_req && !bus.m1_lock && (tenure_q == TEN_MAX))
          state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase

    // Saturation (not wrap) lets a locked owner hand over on the first unlocked edge.
    if ((state_d != state_q) || !contested) tenure_d = '0;
    else if (tenure_q != TEN_MAX)           tenure_d = tenure_q + CW'(1);

    if (state_d != state_q) begin
      if (state_d == GNT0) last_owner_d = 1'b0;
      if (state_d == GNT1) last_owner_d = 1'b1;
    end
  end

  assign bus.m0_gnt    = (state_q == GNT0);
  assign bus.m1_gnt    = (state_q == GNT1);
  assign bus.bus_owner = state_q;
  assign bus.m_hrdata  = bus.HRDATA;

  always_comb begin
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HWDATA = '0;
    case (state_q)
      GNT0: begin
        bus.HADDR  = bus.m0_haddr;
        bus.HWRITE = bus.m0_hwrite;
        bus.HWDATA = bus.m0_hwdata;
      end
      GNT1: begin
        bus.HADDR  = bus.m1_haddr;
        bus.HWRITE = bus.m1_hwrite;
        bus.HWDATA = bus.m1_hwdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed self-checking bench for ahb_master_arbiter, built with MAX_TENURE=4.
module tb_ahb_master_arbiter;

  logic HCLK;
  logic HRESETn;
  int   errors = 0;
  int   checks = 0;

  ahb_master_arbiter_if bus ();

  ahb_master_arbiter #(.MAX_TENURE(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 1'b0;    bus.m1_req = 1'b0;
    bus.m0_lock = 1'b0;   bus.m1_lock = 1'b0;
    bus.m0_hwrite = 1'b0; bus.m1_hwrite = 1'b0;
    bus.m0_haddr = 32'h0000_1000; bus.m1_haddr = 32'h0000_2000;
    bus.m0_hwdata = 32'h1111_1111; bus.m1_hwdata = 32'h2222_2222;
  endtask

  // Reset pulse kept entirely between clock edges.
  task automatic pulse_reset();
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    HRESETn = 1'b0;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    bus.m0_hwrite = 1'b1; bus.m1_hwrite = 1'b1;
    bus.HRDATA = 32'hDEAD_BEEF;
    tick(); tick();
    got = {bus.m0_gnt, bus.m1_gnt, bus.bus_owner};
    checks++;
    if (got !== 4'b0000) begin
      errors++; $display("FAIL reset_owner got=%b exp=0000", got);
    end
    checks++;
    if ({bus.HWRITE, bus.HADDR, bus.HWDATA} !== 65'd0) begin
      errors++; $display("FAIL reset_bus hwrite=%b haddr=%h hwdata=%h exp=0", bus.HWRITE, bus.HADDR, bus.HWDATA);
    end
    checks++;
    if (bus.m_hrdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_hrdata got=%h exp=deadbeef", bus.m_hrdata);
    end
    HRESETn = 1'b1;
    tick();
    got = {bus.m0_gnt, bus.m1_gnt, bus.bus_owner};
    checks++;
    if (got !== 4'b1001) begin
      errors++; $display("FAIL reset_first_tie got=%b exp=1001", got);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    idle_inputs();
    bus.m1_hwrite = 1'b1;
    bus.m1_haddr  = 32'h4000_0000;
    #1;
    checks++;
    if ({bus.HWRITE, bus.HADDR} !== 33'd0) begin
      errors++; $display("FAIL single_idle_nogrant_write hwrite=%b haddr=%h exp=0", bus.HWRITE, bus.HADDR);
    end
    bus.m0_req = 1'b1; bus.m0_hwrite = 1'b1;
    bus.m0_haddr = 32'h2000_0004; bus.m0_hwdata = 32'hA5A5_0001;
    #1;
    checks++;
    if (bus.m0_gnt !== 1'b0) begin
      errors++; $display("FAIL single_gnt_before_edge got=%b exp=0", bus.m0_gnt);
    end
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner} !== 4'b1001) begin
      errors++; $display("FAIL single_gnt got=%b exp=1001", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner});
    end
    checks++;
    if ({bus.HWRITE, bus.HADDR, bus.HWDATA} !== {1'b1, 32'h2000_0004, 32'hA5A5_0001}) begin
      errors++; $display("FAIL single_mux hwrite=%b haddr=%h hwdata=%h exp=1/20000004/a5a50001", bus.HWRITE, bus.HADDR, bus.HWDATA);
    end
    bus.m0_hwrite = 1'b0;
    bus.HRDATA = 32'h0BAD_F00D;
    #1;
    checks++;
    if ({bus.HWRITE, bus.m_hrdata} !== {1'b0, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL single_read hwrite=%b hrdata=%h exp=0/0badf00d", bus.HWRITE, bus.m_hrdata);
    end
    bus.m0_req = 1'b0;
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner} !== 4'b0000) begin
      errors++; $display("FAIL single_release got=%b exp=0000", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner});
    end
  endtask

  task automatic test_tie_handoff();
    idle_inputs();
    pulse_reset();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner} !== 4'b1001) begin
      errors++; $display("FAIL tie_first got=%b exp=1001", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner});
    end
    bus.m0_req = 1'b0;
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner, bus.HADDR} !== {4'b0110, 32'h0000_2000}) begin
      errors++; $display("FAIL handoff_no_idle got=%b haddr=%h exp=0110/00002000", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner}, bus.HADDR);
    end
    bus.m1_req = 1'b0;
    tick();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner} !== 4'b1001) begin
      errors++; $display("FAIL tie_after_m1 got=%b exp=1001", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner});
    end
    idle_inputs();
    tick();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner} !== 4'b0110) begin
      errors++; $display("FAIL tie_after_m0 got=%b exp=0110", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_tenure();
    logic [3:0]  exp;
    logic [31:0] exp_addr;
    idle_inputs();
    pulse_reset();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp      = (((k - 1) / 4) % 2 == 0) ? 4'b1001 : 4'b0110;
      exp_addr = (((k - 1) / 4) % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
      checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner, bus.HADDR} !== {exp, exp_addr}) begin
        errors++; $display("FAIL tenure_cycle%0d got=%b haddr=%h exp=%b/%h", k, {bus.m0_gnt, bus.m1_gnt, bus.bus_owner}, bus.HADDR, exp, exp_addr);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock();
    int held;
    idle_inputs();
    pulse_reset();
    bus.m0_req = 1'b1;
    tick();
    bus.m0_lock = 1'b1; bus.m1_req = 1'b1;
    held = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.m0_gnt === 1'b1 && bus.m1_gnt === 1'b0) held++;
    end
    checks++;
    if (held != 12) begin
      errors++; $display("FAIL lock_hold got=%0d cycles exp=12", held);
    end
    bus.m0_lock = 1'b0;
    #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
      errors++; $display("FAIL lock_release_before_edge got=%b exp=10", {bus.m0_gnt, bus.m1_gnt});
    end
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner} !== 4'b0110) begin
      errors++; $display("FAIL lock_handover got=%b exp=0110", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    pulse_reset();
    bus.m1_req = 1'b1; bus.m1_hwrite = 1'b1; bus.m1_haddr = 32'h3000_0010;
    tick();
    checks++;
    if ({bus.m1_gnt, bus.HWRITE, bus.HADDR} !== {2'b11, 32'h3000_0010}) begin
      errors++; $display("FAIL async_pre_gnt gnt=%b hwrite=%b haddr=%h exp=1/1/30000010", bus.m1_gnt, bus.HWRITE, bus.HADDR);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({bus.m1_gnt, bus.HWRITE, bus.HADDR, bus.bus_owner} !== 36'd0) begin
      errors++; $display("FAIL async_drop gnt=%b hwrite=%b haddr=%h owner=%b exp=0", bus.m1_gnt, bus.HWRITE, bus.HADDR, bus.bus_owner);
    end
    tick();
    HRESETn = 1'b1;
    tick();
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.bus_owner, bus.HWRITE} !== 5'b01101) begin
      errors++; $display("FAIL async_regrant got=%b exp=01101", {bus.m0_gnt, bus.m1_gnt, bus.bus_owner, bus.HWRITE});
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    bus.HRDATA = '0;
    HRESETn = 1'b0;
    test_reset();
    test_single();
    test_tie_handoff();
    test_tenure();
    test_lock();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-master arbiter for the single-cycle AHB-lite bus of the multicycle ARM system. It grants bus ownership to the CPU (M0) or a second master such as DMA or debug (M1), and muxes the owner's address, write and data onto the shared slave bus (GPIO, memory). Arbitration is round-robin with a bounded tenure and a lock override. Bus transfers keep the system convention: address, HWRITE and HWDATA are presented in the same cycle, and the slave commits on the next HCLK rising edge.

## Interface
Parameters:
- MAX_TENURE, 8: maximum consecutive contested cycles an unlocked owner keeps the grant (legal range 1..255).

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- m0_req, m1_req  in  1  master requests bus; held while transfers remain.
- m0_lock, m1_lock  in  1  owner forbids preemption while high; ignored when not owner.
- m0_haddr, m1_haddr  in  32  master address.
- m0_hwrite, m1_hwrite  in  1  master write strobe.
- m0_hwdata, m1_hwdata  in  32  master write data.
- m0_gnt, m1_gnt  out  1  grant; at most one high.
- HADDR  out  32  muxed address to decoder/slaves.
- HWRITE  out  1  muxed write strobe, gated by grant.
- HWDATA  out  32  muxed write data.
- HRDATA  in  32  read data from the slave mux.
- m_hrdata  out  32  HRDATA broadcast unchanged to both masters.
- bus_owner  out  2  2'b00 none, 2'b01 M0, 2'b10 M1.

## Operation
- FSM states: IDLE, GNT0, GNT1. Grants and bus_owner decode from registered state only.
- IDLE: drive HADDR=0, HWRITE=0, HWDATA=0.
  - One request: go to that master's GNT state.
  - Both request: grant the master that is not last_owner.
  - last_owner resets to M1, so M0 wins the first tie.
- GNTx, owner req low: go to GNTy if the other master requests, otherwise IDLE. The handoff to GNTy has no idle cycle.
- GNTx, owner req high:
  - Stay in GNTx unless preempted.
  - Preemption occurs at the edge where the other master's req=1, owner lock=0 and tenure_cnt==MAX_TENURE-1. The next state is GNTy.
- tenure_cnt, width $clog2(MAX_TENURE+1):
  - Clears on every state change and in any cycle the other master's req is low.
  - Increments in contested GNT cycles, saturating at MAX_TENURE-1.
  - If the owner's lock is high at saturation, the owner holds the grant. The handover then occurs at the first edge where lock is low.
- last_owner updates to x on every entry into GNTx.
- Bus mux in GNTx: HADDR/HWDATA = mx_haddr/mx_hwdata, and HWRITE = mx_hwrite.
- A non-owner's hwrite never reaches HWRITE. Writes a master presents without a grant are dropped, and retrying them is the master's responsibility.
- A lock held indefinitely starves the other master. This is permitted, and avoiding it is software's responsibility.

## Timing
- Reset (asynchronous, immediate on HRESETn low):
  - State IDLE, tenure_cnt=0, last_owner=M1.
  - m0_gnt=m1_gnt=0, bus_owner=00.
  - HWRITE=0, HADDR=0, HWDATA=0.
- Grant latency from IDLE: req sampled high at edge N gives gnt high after edge N. The first transfer commits at edge N+1.
- Release latency: owner req low sampled at edge N gives gnt low after edge N. The other master's gnt rises in the same cycle if it is requesting.
- Bus outputs are combinational from state and master inputs: zero added latency, with the mux path only.
- m_hrdata = HRDATA combinationally, in every state.
- Simultaneous owner release and preemption condition at the same edge: the result is identical (GNTy).
- Reset during GNTx: the grant and HWRITE drop asynchronously, and any in-flight write is not committed if reset precedes the edge.

## Test plan
- Reset: assert HRESETn=0 with both req=1 → gnts 0, bus_owner=00, HWRITE=0, HADDR=0; release → M0 granted after first edge.
- Single master: M0 req with haddr=0x2000_0004, hwrite=1, hwdata=0xA5A5_0001 → m0_gnt=1 after one edge; HADDR/HWDATA/HWRITE match M0; M1 hwrite=1 with no req gives HWRITE=0 in IDLE.
- Tie and handoff: both req from IDLE → GNT0; M0 drops req → m1_gnt=1 on the very next cycle with no IDLE cycle; next tie from IDLE → M0 granted.
- Tenure: MAX_TENURE=4, both req held continuously → grants alternate exactly 4 cycles M0, 4 cycles M1, repeating; bus_owner toggles 01/10 accordingly.
- Lock: MAX_TENURE=4, M0 owner with m0_lock=1 and M1 req held for 12 cycles → M0 holds all 12; m0_lock low → M1 granted after the next edge.
- Async reset mid-GNT1: M1 writing every cycle, pulse HRESETn low between edges → m1_gnt and HWRITE fall before the next edge, HADDR=0, bus_owner=00.
